// File: rtl/serv_ibus_prefetch.sv
// Single-entry sequential instruction prefetch buffer for the SERV ibus.
// Prefetching is compiled in only when SERV_IBUS_PREFETCH_EN is defined.
module serv_ibus_prefetch (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_cpu_adr,
    input  logic        i_cpu_cyc,
    output logic [31:0] o_cpu_rdt,
    output logic        o_cpu_ack,
    input  logic        i_flush,
    output logic [31:0] o_wb_adr,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_hit
);

    typedef enum logic [1:0] {
        IDLE,
        DEMAND,
        PREFETCH,
        DRAIN
    } state_t;

    state_t      state;
    logic [29:0] adr;
    logic [29:0] req_adr;
    logic        req;

    assign req_adr  = i_cpu_adr[31:2];
    // A request still visible during its own ack cycle is stale.
    assign req      = i_cpu_cyc & ~o_cpu_ack;
    assign o_wb_adr = {adr, 2'b00};

`ifdef SERV_IBUS_PREFETCH_EN
    logic [29:0] tag;
    logic [31:0] data;
    logic        valid;
    logic        killed;
    logic        kill;
    logic        unused;

    assign kill   = killed | i_flush;
    assign unused = &{1'b0, i_cpu_adr[1:0]};
`else
    logic        unused;

    assign o_hit  = 1'b0;
    assign unused = &{1'b0, i_cpu_adr[1:0], i_flush};
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            adr       <= '0;
            o_wb_cyc  <= 1'b0;
            o_cpu_ack <= 1'b0;
            o_cpu_rdt <= '0;
`ifdef SERV_IBUS_PREFETCH_EN
            o_hit     <= 1'b0;
            tag       <= '0;
            data      <= '0;
            valid     <= 1'b0;
            killed    <= 1'b0;
`endif
        end else begin
            o_cpu_ack <= 1'b0;
`ifdef SERV_IBUS_PREFETCH_EN
            o_hit     <= 1'b0;
            if (i_flush)
                valid <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (req) begin
`ifdef SERV_IBUS_PREFETCH_EN
                        valid <= 1'b0;
                        if (valid && !i_flush && tag == req_adr) begin
                            o_cpu_ack <= 1'b1;
                            o_hit     <= 1'b1;
                            o_cpu_rdt <= data;
                            adr       <= tag + 30'd1;
                            o_wb_cyc  <= 1'b1;
                            killed    <= 1'b0;
                            state     <= PREFETCH;
                        end else begin
                            adr      <= req_adr;
                            o_wb_cyc <= 1'b1;
                            state    <= DEMAND;
                        end
`else
                        adr      <= req_adr;
                        o_wb_cyc <= 1'b1;
                        state    <= DEMAND;
`endif
                    end
                end
                DEMAND: begin
                    if (!o_wb_cyc) begin
                        o_wb_cyc <= 1'b1;
                    end else if (i_wb_ack) begin
                        o_wb_cyc  <= 1'b0;
                        o_cpu_ack <= 1'b1;
                        o_cpu_rdt <= i_wb_rdt;
`ifdef SERV_IBUS_PREFETCH_EN
                        adr       <= adr + 30'd1;
                        killed    <= 1'b0;
                        state     <= PREFETCH;
`else
                        state     <= IDLE;
`endif
                    end
                end
`ifdef SERV_IBUS_PREFETCH_EN
                PREFETCH: begin
                    if (i_flush)
                        killed <= 1'b1;
                    if (!o_wb_cyc) begin
                        o_wb_cyc <= 1'b1;
                    end else if (i_wb_ack) begin
                        o_wb_cyc <= 1'b0;
                        if (req && req_adr == adr && !kill) begin
                            o_cpu_ack <= 1'b1;
                            o_cpu_rdt <= i_wb_rdt;
                            adr       <= adr + 30'd1;
                            killed    <= 1'b0;
                        end else if (req) begin
                            // Wrong or flushed word: drop it, refetch demand.
                            adr   <= req_adr;
                            state <= DEMAND;
                        end else begin
                            state <= IDLE;
                            if (!kill) begin
                                tag   <= adr;
                                data  <= i_wb_rdt;
                                valid <= 1'b1;
                            end
                        end
                    end
                end
`endif
                default: begin
                    o_wb_cyc <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
